// File: rtl/mu0_program_loader.sv
// mu0_program_loader: boot loader that writes a length-prefixed byte-stream image into MU0 memory, then releases the CPU
// Ports: clk/rst (sync, active high); s_byte/s_valid/s_ready byte stream in; reload re-arms from RUN;
//        cpu_* MU0 bus in; mem_* memory bus out; cpu_rst_n MU0 reset; done load complete; overflow sticky image too long.
module mu0_program_loader #(
    parameter int MEM_DEPTH = 32,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_byte,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              reload,
    input  logic [DATA_W-1:0] cpu_out_data,
    input  logic [ADDR_W-1:0] cpu_out_address,
    input  logic              cpu_memrq,
    input  logic              cpu_rnw,
    output logic [DATA_W-1:0] mem_in_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_memrq,
    output logic              mem_rw,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              overflow
);
    typedef enum logic [2:0] {HDR_HI, HDR_LO, W_HI, W_LO, WRITE, RUN} state_t;
    state_t      state;
    logic [15:0] n, wp;
    logic [7:0]  hi, lo;
    logic        run, wr;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HDR_HI;
            n        <= '0;
            wp       <= '0;
            hi       <= '0;
            lo       <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                HDR_HI: if (s_valid) begin
                    n[15:8] <= s_byte;
                    state   <= HDR_LO;
                end
                HDR_LO: if (s_valid) begin
                    n[7:0] <= s_byte;
                    state  <= ({n[15:8], s_byte} == 16'd0) ? RUN : W_HI;
                end
                W_HI: if (s_valid) begin
                    hi    <= s_byte;
                    state <= W_LO;
                end
                W_LO: if (s_valid) begin
                    lo    <= s_byte;
                    state <= WRITE;
                end
                WRITE: begin
                    if (32'(wp) >= MEM_DEPTH) overflow <= 1'b1;
                    wp    <= wp + 16'd1;
                    // 17-bit compare so N=65535 terminates without wrapping
                    state <= (17'(wp) + 17'd1 == 17'(n)) ? RUN : W_HI;
                end
                RUN: if (reload) begin
                    state    <= HDR_HI;
                    n        <= '0;
                    wp       <= '0;
                    overflow <= 1'b0;
                end
                default: state <= HDR_HI;
            endcase
        end
    end
    // Bus outputs depend only on registers, except the RUN pass-through of the CPU bus
    always_comb begin
        run         = state == RUN;
        wr          = state == WRITE && 32'(wp) < MEM_DEPTH;
        s_ready     = state != WRITE && !run;
        cpu_rst_n   = run;
        done        = run;
        mem_memrq   = run ? cpu_memrq : wr;
        mem_rw      = run ? cpu_rnw : !wr;
        mem_addr    = run ? cpu_out_address : wr ? ADDR_W'(wp) : '0;
        mem_in_data = run ? cpu_out_data : wr ? DATA_W'({hi, lo}) : '0;
    end
endmodule

// File: doc/mu0_program_loader.md
Name: mu0_program_loader

Overview:
- Boot-time stage between a byte-stream source (e.g. UART receiver) and the MU0 / memory_32x16 bus.
- Receives a length-prefixed program image, assembles 16-bit words and writes them sequentially into memory from address 0, holding the MU0 in reset meanwhile.
- After the last word it hands the memory bus to the MU0 and releases the CPU from reset. This replaces forced preloading in benches and on silicon.

Parameters:
- MEM_DEPTH, 32, number of writable memory words; also the overflow limit.
- ADDR_W, 12, width of the memory/CPU address bus.
- DATA_W, 16, word width. Fixed at 2 bytes per word.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_byte  in  8  stream byte.
- s_valid  in  1  s_byte valid.
- s_ready  out  1  loader can accept a byte.
- reload  in  1  single-cycle request to reload; honoured only in RUN.
- cpu_out_data  in  DATA_W  MU0 write data.
- cpu_out_address  in  ADDR_W  MU0 address.
- cpu_memrq  in  1  MU0 memory request.
- cpu_rnw  in  1  MU0 read-not-write.
- mem_in_data  out  DATA_W  to memory in_data.
- mem_addr  out  ADDR_W  to memory addr.
- mem_memrq  out  1  to memory memrq.
- mem_rw  out  1  to memory rw (1 = read, 0 = write).
- cpu_rst_n  out  1  to MU0 rst_n; low holds the CPU in reset.
- done  out  1  load complete; CPU running.
- overflow  out  1  sticky; image exceeded MEM_DEPTH.

Behaviour:
- Reset (rst=1 at an edge): state=HDR_HI, word count N=0, write pointer wp=0, overflow=0, byte holding register=0.
  - Outputs during and after reset until RUN: cpu_rst_n=0, done=0, s_ready=1.
  - Memory bus idle: mem_memrq=0, mem_rw=1, mem_addr=0, mem_in_data=0.
- Transfer rule: a byte transfers on an edge where s_valid && s_ready. s_valid may drop between bytes with no effect.
- s_ready is high in HDR_HI, HDR_LO, W_HI, W_LO. It is low in WRITE and RUN.
- Image format: N[15:8], N[7:0], then N words, each high byte first.
- FSM:
  - HDR_HI: on transfer, N[15:8]=byte, go to HDR_LO.
  - HDR_LO: on transfer, N[7:0]=byte. Go to RUN if the full N equals 0; otherwise go to W_HI.
  - W_HI: on transfer, latch the high byte, go to W_LO.
  - W_LO: on transfer, latch the low byte, go to WRITE.
  - WRITE: exactly one cycle.
    - If wp<MEM_DEPTH: mem_memrq=1, mem_rw=0, mem_addr=wp, mem_in_data={hi,lo}; the memory captures at the end of this cycle.
    - If wp>=MEM_DEPTH: no request (mem_memrq=0) and overflow<=1.
    - wp<=wp+1, a 16-bit counter that must not wrap for N≤65535.
    - Go to RUN if wp+1==N, else go to W_HI.
  - RUN: done=1, cpu_rst_n=1. Memory bus is combinational pass-through: mem_in_data=cpu_out_data, mem_addr=cpu_out_address, mem_memrq=cpu_memrq, mem_rw=cpu_rnw.
    - reload=1: next state HDR_HI with wp=0, N=0, overflow=0. cpu_rst_n and done fall in the same cycle the state leaves RUN. Memory contents are untouched.
- reload outside RUN is ignored.
- Latency: if the last low byte transfers at edge k, the WRITE cycle is between edges k and k+1, and cpu_rst_n/done are high from edge k+1.
- N=0 case: RUN is entered on the edge that accepts N[7:0]; there are no writes.
- Overflow: words beyond MEM_DEPTH are consumed to keep stream framing but are not written.
- rst mid-load: abort immediately to the reset state. Partially written memory is left as is, and the CPU stays in reset.
- cpu_* inputs are ignored outside RUN.
- mem_* and cpu_rst_n are combinational from the state register and the word/pointer registers only. There is no combinational path from s_valid.

Test Plan:
- Load 19-word image (N=0x0013):
  - Stimulus: words 0x4005, 0x0011, 0x3011, 0x6000, 0x5010, 0x0011, 0x0012, 0x1011, 0x0011, 0x2011, 0x1012, 0x0011, 0x3012, 0x5010, 0x6001, 0x4000, 0x7000, 0x00F0, 0x000D.
  - Required: memory M[0]=0x4005, M[16]=0x7000, M[17]=0x00F0, M[18]=0x000D; exactly 19 write cycles; cpu_rst_n rises one edge after the last byte; then MU0 runs and reaches STOP.
- N=0 -> done=1 and cpu_rst_n=1 on the edge accepting the second header byte; mem_memrq never asserted by the loader.
- N=34 with MEM_DEPTH=32 -> M[0..31] written; words 32 and 33 consumed with no memrq; overflow=1; done=1 after 70 bytes.
- Random s_valid gaps (0–5 idle cycles) with a 3-word image -> memory contents identical to the gap-free run; s_ready=0 during each WRITE cycle.
- In RUN, pulse reload, then send N=1 and word 0x7000 -> cpu_rst_n=0 from the cycle after reload until reload completes; M[0]=0x7000; M[1..] unchanged; overflow cleared.
- Assert rst after 2 of 5 words -> state returns to HDR_HI; cpu_rst_n=0; a fresh header is accepted; M[0], M[1] retain the words already written until overwritten.
